fdiv_seq: RTL and testbench
===========================

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter MW, default 23, stored-mantissa width; word width W = 1+EW+MW.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port ready  output  1  high in IDLE only.
REQ-007 SHALL have port a  input  W  dividend, IEEE-style sign/exp/mantissa.
REQ-008 SHALL have port b  input  W  divisor.
REQ-009 SHALL have port rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 SHALL have port done  output  1  one-cycle pulse, q/flags valid.
REQ-011 SHALL have port q  output  W  quotient, held until next accepted start.
REQ-012 SHALL have port flags  output  5  {invalid, divzero, overflow, underflow, inexact}, held with q.

Function
REQ-013 SHALL capture a, b, rm on the edge where start=1 and ready=1; later input changes do not affect the operation.
REQ-014 SHALL run FSM IDLE -> PREP (1 cycle) -> DIV (MW+3 cycles) -> ROUND (1 cycle) -> IDLE, with done=1 in the cycle after ROUND.
REQ-015 SHALL assert done exactly MW+5 edges after the accepting edge (28 for defaults), for all operands including specials (fixed latency).
REQ-016 SHALL ignore start while not in IDLE; accepting a new start in the cycle done=1 is allowed.
REQ-017 SHALL in PREP compute sign = sa^sb, exponent ea-eb+bias, and if ma<mb shift ma left 1 and decrement exponent so the quotient lies in [1,2).
REQ-018 SHALL in DIV produce one quotient bit per cycle by restoring division (MW+1 significand bits, guard, round); sticky = remainder nonzero.
REQ-019 SHALL round per rm using guard/round/sticky; mantissa carry-out renormalises and increments exponent.
REQ-020 SHALL flush subnormal inputs to signed zero before classification.
REQ-021 SHALL on exponent overflow return inf (RNE; RUP if positive; RDN if negative) else max finite, setting overflow and inexact.
REQ-022 SHALL on result below min normal return signed zero, setting underflow and inexact.
REQ-023 SHALL return canonical qNaN (sign 0, exp all ones, mantissa MSB only) with invalid for any NaN input, 0/0, inf/inf.
REQ-024 SHALL return signed inf with divzero for finite-nonzero/0; signed inf for inf/finite; signed zero for 0/finite-nonzero and finite/inf; no flags for these.
REQ-025 SHALL set inexact iff guard|round|sticky nonzero for finite results.

Reset
REQ-026 SHALL on reset=0, at any time including mid-operation, force IDLE, ready=1, done=0, q=0, flags=0, and clear datapath registers.
REQ-027 SHALL accept no start while reset=0; first acceptance is on an edge after deassertion.

Structure
REQ-028 SHALL place state enum (IDLE, PREP, DIV, ROUND), rm encodings and flag bit indices in shared package fdiv_pkg.
REQ-029 SHALL implement rounding/overflow/underflow in a combinational sub-module fdiv_round, parametrised by EW, MW.
REQ-030 SHALL use a single iteration counter of width clog2(MW+4) and no multipliers.

Verification
REQ-031 SHALL cover 0x40C00000 / 0x40400000, rm=00 -> q=0x40000000, flags=0, done at edge 28.
REQ-032 SHALL cover 0x3F800000 / 0x40400000 -> rm=00 q=0x3EAAAAAB, rm=01 q=0x3EAAAAAA, inexact=1.
REQ-033 SHALL cover 0x3F800000 / 0x00000000 -> q=0x7F800000, divzero=1; 0x00000000 / 0x00000000 -> q=0x7FC00000, invalid=1.
REQ-034 SHALL cover 0x7F7FFFFF / 0x3F000000 -> rm=00 q=0x7F800000, rm=01 q=0x7F7FFFFF, overflow=1, inexact=1.
REQ-035 SHALL cover start pulsed during DIV -> ignored, first result unchanged; reset=0 at edge 10 -> ready=1, q=0, no done.

Source files
------------

// File: rtl/fdiv_pkg.sv
// ---------------------------------------------------------------------------
// fdiv_pkg
// Shared definitions for the sequential floating-point divider:
//   - state_e       : controller states (IDLE, PREP, DIV, ROUND)
//   - RM_*          : rounding-mode encodings carried on the rm input
//   - FLAG_*        : bit positions inside the 5-bit flags vector
//                     {invalid, divzero, overflow, underflow, inexact}
//   - roundUp()     : increment decision from rounding mode, sign, LSB and
//                     guard/round/sticky bits
// ---------------------------------------------------------------------------
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        DIV   = 2'd2,
        ROUND = 2'd3
    } state_e;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // RNE bumps when the discarded part is above half, or exactly half with
    // an odd LSB; the directed modes bump on any discarded bit when the
    // direction moves the magnitude away from zero.
    function automatic logic roundUp(input logic [1:0] mode,
                                     input logic       sign,
                                     input logic       lsb,
                                     input logic       guard,
                                     input logic       rnd,
                                     input logic       sticky);
        logic up;
        case (mode)
            RM_RNE:  up = guard & (rnd | sticky | lsb);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (guard | rnd | sticky);
            default: up = ~sign & (guard | rnd | sticky);
        endcase
        return up;
    endfunction

endpackage

// File: rtl/fdiv_round.sv
// ---------------------------------------------------------------------------
// fdiv_round
// Combinational rounding / range stage for finite quotients.
// Ports:
//   sign_i   : quotient sign
//   exp_i    : biased exponent before rounding (signed, two extra bits so
//              that overflow and underflow are visible)
//   sig_i    : MW+1 significand bits (hidden bit at MSB), then guard, round
//   sticky_i : OR of everything below the round bit
//   rm_i     : rounding mode (RM_* in fdiv_pkg)
//   res_o    : packed {sign, exponent, mantissa} result
//   flags_o  : {invalid, divzero, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fdiv_round
    import fdiv_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic                 sign_i,
    input  logic signed [EW+1:0] exp_i,
    input  logic [MW+2:0]        sig_i,
    input  logic                 sticky_i,
    input  logic [1:0]           rm_i,
    output logic [EW+MW:0]       res_o,
    output logic [4:0]           flags_o
);

    localparam int EXP_ONES = (1 << EW) - 1;

    logic                 inexact;
    logic                 up;
    logic                 toInf;
    logic [MW+1:0]        mantSum;
    logic signed [EW+1:0] expRnd;

    // Round the significand, let a carry out of the mantissa bump the
    // exponent (the mantissa field is then all zeros), and only afterwards
    // decide whether the result left the normal range.
    always_comb begin
        inexact = sig_i[1] | sig_i[0] | sticky_i;
        up      = roundUp(rm_i, sign_i, sig_i[2], sig_i[1], sig_i[0], sticky_i);
        mantSum = {1'b0, sig_i[MW+2:2]} + {{(MW+1){1'b0}}, up};
        expRnd  = exp_i + $signed({{(EW+1){1'b0}}, mantSum[MW+1]});
        toInf   = (rm_i == RM_RNE) ||
                  (rm_i == RM_RUP && !sign_i) ||
                  (rm_i == RM_RDN && sign_i);
        flags_o = '0;
        res_o   = '0;
        if (int'(expRnd) >= EXP_ONES) begin
            flags_o[FLAG_OVERFLOW] = 1'b1;
            flags_o[FLAG_INEXACT]  = 1'b1;
            res_o = toInf ? {sign_i, {EW{1'b1}}, {MW{1'b0}}}
                          : {sign_i, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
        end else if (int'(expRnd) <= 0) begin
            flags_o[FLAG_UNDERFLOW] = 1'b1;
            flags_o[FLAG_INEXACT]   = 1'b1;
            res_o = {sign_i, {(EW+MW){1'b0}}};
        end else begin
            flags_o[FLAG_INEXACT] = inexact;
            res_o = {sign_i, expRnd[EW-1:0], mantSum[MW-1:0]};
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// ---------------------------------------------------------------------------
// fdiv_seq
// Fixed-latency sequential floating-point divider (restoring division, one
// quotient bit per cycle). Subnormal inputs are flushed to signed zero.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   start : request, taken only while ready is high
//   ready : high while idle
//   a, b  : dividend / divisor, {sign, exponent[EW], mantissa[MW]}
//   rm    : rounding mode (00 RNE, 01 RTZ, 10 RDN, 11 RUP)
//   done  : one-cycle pulse when q/flags have been updated
//   q     : quotient, held between operations
//   flags : {invalid, divzero, overflow, underflow, inexact}, held with q
// Latency: done rises MW+5 edges after the accepting edge for every operand.
// ---------------------------------------------------------------------------
module fdiv_seq
    import fdiv_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           ready,
    input  logic [EW+MW:0] a,
    input  logic [EW+MW:0] b,
    input  logic [1:0]     rm,
    output logic           done,
    output logic [EW+MW:0] q,
    output logic [4:0]     flags
);

    localparam int W    = 1 + EW + MW;
    localparam int CW   = $clog2(MW + 4);
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(MW + 2);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         aOp_q, aOp_d, bOp_q, bOp_d;
    logic [1:0]           rm_q, rm_d;
    logic                 sign_q, sign_d;
    logic signed [EW+1:0] exp_q, exp_d;
    logic [MW+1:0]        rem_q, rem_d;
    logic [MW:0]          divisor_q, divisor_d;
    logic [MW+2:0]        quo_q, quo_d;
    logic                 special_q, special_d;
    logic [W-1:0]         specRes_q, specRes_d;
    logic [4:0]           specFlags_q, specFlags_d;
    logic [W-1:0]         res_q, res_d;
    logic [4:0]           flags_q, flags_d;
    logic                 done_q, done_d;

    logic [EW-1:0]        expA, expB;
    logic [MW-1:0]        fracA, fracB;
    logic [MW:0]          mantA, mantB;
    logic                 aZero, bZero, aInf, bInf, aNan, bNan;
    logic                 opSign, mantLess;
    logic signed [EW+1:0] expPrep;
    logic                 specHit;
    logic [W-1:0]         specRes;
    logic [4:0]           specFlags;
    logic                 remNonZero;
    logic [W-1:0]         rndRes;
    logic [4:0]           rndFlags;

    assign expA   = aOp_q[W-2:MW];
    assign expB   = bOp_q[W-2:MW];
    assign fracA  = aOp_q[MW-1:0];
    assign fracB  = bOp_q[MW-1:0];
    assign opSign = aOp_q[W-1] ^ bOp_q[W-1];

    // A zero exponent field covers both true zero and subnormals, which are
    // treated as signed zero.
    assign aZero = (expA == '0);
    assign bZero = (expB == '0);
    assign aInf  = (expA == '1) && (fracA == '0);
    assign bInf  = (expB == '1) && (fracB == '0);
    assign aNan  = (expA == '1) && (fracA != '0);
    assign bNan  = (expB == '1) && (fracB != '0);

    // Pre-normalise: when the dividend significand is the smaller one, it is
    // doubled so the quotient lands in [1,2) and the exponent drops by one.
    assign mantA    = {1'b1, fracA};
    assign mantB    = {1'b1, fracB};
    assign mantLess = (mantA < mantB);
    assign expPrep  = $signed({2'b00, expA}) - $signed({2'b00, expB})
                    + $signed((EW+2)'(BIAS))
                    - $signed({{(EW+1){1'b0}}, mantLess});

    // Special-operand outcome. It is decided up front but only published in
    // ROUND, so specials keep the same latency as ordinary quotients.
    always_comb begin
        specHit   = 1'b1;
        specRes   = '0;
        specFlags = '0;
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            specRes = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            specFlags[FLAG_INVALID] = 1'b1;
        end else if (aInf) begin
            specRes = {opSign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (bZero) begin
            specRes = {opSign, {EW{1'b1}}, {MW{1'b0}}};
            specFlags[FLAG_DIVZERO] = 1'b1;
        end else if (aZero || bInf) begin
            specRes = {opSign, {(W-1){1'b0}}};
        end else begin
            specHit = 1'b0;
        end
    end

    assign remNonZero = |rem_q;

    fdiv_round #(
        .EW(EW),
        .MW(MW)
    ) u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .sig_i    (quo_q),
        .sticky_i (remNonZero),
        .rm_i     (rm_q),
        .res_o    (rndRes),
        .flags_o  (rndFlags)
    );

    // Controller and datapath next state. The partial remainder always stays
    // below twice the divisor, so MW+2 bits hold it and the left shift after
    // each step never drops a set bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aOp_d       = aOp_q;
        bOp_d       = bOp_q;
        rm_d        = rm_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        quo_d       = quo_q;
        special_d   = special_q;
        specRes_d   = specRes_q;
        specFlags_d = specFlags_q;
        res_d       = res_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aOp_d   = a;
                    bOp_d   = b;
                    rm_d    = rm;
                    state_d = PREP;
                end
            end
            PREP: begin
                sign_d      = opSign;
                exp_d       = expPrep;
                rem_d       = mantLess ? {mantA, 1'b0} : {1'b0, mantA};
                divisor_d   = mantB;
                quo_d       = '0;
                cnt_d       = '0;
                special_d   = specHit;
                specRes_d   = specRes;
                specFlags_d = specFlags;
                state_d     = DIV;
            end
            DIV: begin
                if (rem_q >= {1'b0, divisor_q}) begin
                    rem_d = (rem_q - {1'b0, divisor_q}) << 1;
                    quo_d = {quo_q[MW+1:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    quo_d = {quo_q[MW+1:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                res_d   = special_q ? specRes_q : rndRes;
                flags_d = special_q ? specFlags_q : rndFlags;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset may strike mid-operation and returns everything
    // to an idle, zeroed divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aOp_q       <= '0;
            bOp_q       <= '0;
            rm_q        <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            quo_q       <= '0;
            special_q   <= 1'b0;
            specRes_q   <= '0;
            specFlags_q <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aOp_q       <= aOp_d;
            bOp_q       <= bOp_d;
            rm_q        <= rm_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            quo_q       <= quo_d;
            special_q   <= special_d;
            specRes_q   <= specRes_d;
            specFlags_q <= specFlags_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign q     = res_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_fdiv_seq
// Self-checking bench for fdiv_seq (EW=8, MW=23): directed vectors, ignored
// start pulses, mid-operation reset, back-to-back issue and random operands
// compared against a reference built from integer division.
// ---------------------------------------------------------------------------
module tb_fdiv_seq;

    localparam int EW  = 8;
    localparam int MW  = 23;
    localparam int LAT = MW + 5;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic        done;
    logic [31:0] q;
    logic [4:0]  flags;

    int errors = 0;
    int checks = 0;

    fdiv_seq #(
        .EW(EW),
        .MW(MW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ready (ready),
        .a     (a),
        .b     (b),
        .rm    (rm),
        .done  (done),
        .q     (q),
        .flags (flags)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference quotient: exact integer division of the scaled significands,
    // rounding decided by comparing the discarded fraction against one half.
    function automatic void refDiv(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] mode,
                                   output logic [31:0] res, output logic [4:0] f);
        logic   s, xZero, yZero, xInf, yInf, xNan, yNan, sticky, inexact, up;
        int     ex, ey, e, low;
        longint mx, my, num, quo, keep;
        s     = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        xZero = (ex == 0);
        yZero = (ey == 0);
        xInf  = (ex == 255) && (x[22:0] == 0);
        yInf  = (ey == 255) && (y[22:0] == 0);
        xNan  = (ex == 255) && (x[22:0] != 0);
        yNan  = (ey == 255) && (y[22:0] != 0);
        res   = '0;
        f     = '0;
        if (xNan || yNan || (xZero && yZero) || (xInf && yInf)) begin
            res = 32'h7FC00000;
            f   = 5'b10000;
        end else if (xInf) begin
            res = {s, 8'hFF, 23'h0};
        end else if (yZero) begin
            res = {s, 8'hFF, 23'h0};
            f   = 5'b01000;
        end else if (xZero || yInf) begin
            res = {s, 31'h0};
        end else begin
            mx     = longint'({1'b1, x[22:0]});
            my     = longint'({1'b1, y[22:0]});
            num    = mx << 26;
            quo    = num / my;
            sticky = (num % my) != 0;
            e      = ex - ey + 127;
            if (quo >= (longint'(1) << 26)) begin
                sticky = sticky || ((quo & 1) != 0);
                quo    = quo >> 1;
            end else begin
                e = e - 1;
            end
            keep    = quo >> 2;
            low     = int'(quo & 3);
            inexact = (low != 0) || sticky;
            case (mode)
                2'b00:   up = (low == 3) || (low == 2 && (sticky || (keep & 1) != 0));
                2'b01:   up = 1'b0;
                2'b10:   up = s && inexact;
                default: up = !s && inexact;
            endcase
            if (up) keep = keep + 1;
            if (keep == (longint'(1) << 24)) begin
                keep = longint'(1) << 23;
                e    = e + 1;
            end
            if (e >= 255) begin
                f = 5'b00101;
                if (mode == 2'b00 || (mode == 2'b11 && !s) || (mode == 2'b10 && s))
                    res = {s, 8'hFF, 23'h0};
                else
                    res = {s, 8'hFE, 23'h7FFFFF};
            end else if (e <= 0) begin
                f   = 5'b00011;
                res = {s, 31'h0};
            end else begin
                res = {s, 8'(e), 23'(keep)};
                f   = {4'b0000, inexact};
            end
        end
    endfunction

    // Operand generator biased toward specials, extreme exponents and
    // all-ones mantissas so the rare paths show up often.
    function automatic logic [31:0] randOperand();
        int          cat;
        logic [7:0]  e;
        logic [22:0] m;
        cat = int'($urandom_range(0, 11));
        m   = 23'($urandom);
        e   = 8'($urandom_range(100, 154));
        case (cat)
            0: e = 8'h00;
            1: begin e = 8'hFF; m = '0; end
            2: begin e = 8'hFF; if (m == '0) m = 23'h1; end
            3: e = 8'($urandom_range(230, 254));
            4: e = 8'($urandom_range(1, 25));
            5: m = 23'h7FFFFF;
            6: m = '0;
            default: ;
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Issues one operation from a point between edges where ready is high,
    // scrambles the inputs right after the accepting edge, then waits for
    // done with a bounded cycle budget (lat = -1 on timeout).
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic [1:0] opRm,
                                 output logic [31:0] resQ, output logic [4:0] resF,
                                 output int lat);
        a     = opA;
        b     = opB;
        rm    = opRm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        rm    = 2'($urandom);
        lat   = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        resQ = q;
        resF = flags;
    endtask

    task automatic test_reset();
        start = 1'b0;
        a     = '0;
        b     = '0;
        rm    = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (q !== 32'h0) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00000000", q); end
        checks++; if (flags !== 5'h0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", flags); end
        a     = 32'h40C00000;
        b     = 32'h40400000;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_hold_ready: got %b expected 1", ready); end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[9], vb[9], vq[9], gotQ;
        logic [1:0]  vr[9];
        logic [4:0]  vf[9], gotF;
        int          lat;
        va = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000,
               32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'hBF800000};
        vb = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000,
               32'h3F000000, 32'h3F000000, 32'h40000000, 32'h40400000};
        vr = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
        vq = '{32'h40000000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h7F800000, 32'h7FC00000,
               32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 32'hBEAAAAAB};
        vf = '{5'b00000, 5'b00001, 5'b00001, 5'b01000, 5'b10000,
               5'b00101, 5'b00101, 5'b00011, 5'b00001};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(va[i], vb[i], vr[i], gotQ, gotF, lat);
            checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (gotQ !== vq[i]) begin errors++; $display("[TB] FAIL dir%0d_q: got %h expected %h", i, gotQ, vq[i]); end
            checks++; if (gotF !== vf[i]) begin errors++; $display("[TB] FAIL dir%0d_flags: got %b expected %b", i, gotF, vf[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit sawDone;
        a     = 32'h40C00000;
        b     = 32'h40400000;
        rm    = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 11;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (q !== 32'h40000000) begin errors++; $display("[TB] FAIL ignore_q: got %h expected 40000000", q); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("[TB] FAIL ignore_flags: got %b expected 00000", flags); end
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL ignore_extra_done: got %b expected 0", sawDone); end
    endtask

    task automatic test_midreset();
        bit sawDone;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        rm    = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", ready); end
        checks++; if (q !== 32'h0) begin errors++; $display("[TB] FAIL midreset_q: got %h expected 00000000", q); end
        checks++; if (flags !== 5'h0) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 00000", flags); end
        @(negedge clk);
        reset   = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", sawDone); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opA, opB, expQ, gotQ;
        logic [4:0]  expF, gotF;
        logic [1:0]  opRm;
        int          lat;
        applyStimulus(32'h40C00000, 32'h40400000, 2'b00, gotQ, gotF, lat);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_at_done: got %b expected 1", ready); end
        opA  = randOperand();
        opB  = randOperand();
        opRm = 2'($urandom);
        refDiv(opA, opB, opRm, expQ, expF);
        applyStimulus(opA, opB, opRm, gotQ, gotF, lat);
        checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (gotQ !== expQ) begin errors++; $display("[TB] FAIL b2b_q a=%h b=%h: got %h expected %h", opA, opB, gotQ, expQ); end
        checks++; if (gotF !== expF) begin errors++; $display("[TB] FAIL b2b_flags a=%h b=%h: got %b expected %b", opA, opB, gotF, expF); end
    endtask

    task automatic test_random();
        logic [31:0] opA, opB, expQ, gotQ;
        logic [4:0]  expF, gotF;
        logic [1:0]  opRm;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            opA  = randOperand();
            opB  = randOperand();
            opRm = 2'($urandom);
            refDiv(opA, opB, opRm, expQ, expF);
            applyStimulus(opA, opB, opRm, gotQ, gotF, lat);
            checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (gotQ !== expQ) begin errors++; $display("[TB] FAIL rand%0d_q a=%h b=%h rm=%0d: got %h expected %h", i, opA, opB, opRm, gotQ, expQ); end
            checks++; if (gotF !== expF) begin errors++; $display("[TB] FAIL rand%0d_flags a=%h b=%h rm=%0d: got %b expected %b", i, opA, opB, opRm, gotF, expF); end
        end
    endtask

    // Scenario sequence; the mid-operation reset follows an operation whose
    // result is nonzero so the cleared q is observable.
    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
